mem_loader: RTL
===============

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, memory word width in bits; multiple of 8, at least 16.
REQ-002 The block SHALL have parameter DEPTH, default 2048, words per target memory; power of 2; AW = $clog2(DEPTH).
REQ-003 The block SHALL have parameter CH, default 2, number of target memories, range 1..16.
REQ-004 The block SHALL have port clk_i  input  1  single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port dc_i  input  1  byte type: 0 = command, 1 = data; sampled with byte_rdy_i.
REQ-007 The block SHALL have port byte_rdy_i  input  1  one-cycle strobe, byte_data_i valid.
REQ-008 The block SHALL have port byte_data_i  input  8  received byte.
REQ-009 The block SHALL have port wr_en_o  output  1  one-cycle write strobe.
REQ-010 The block SHALL have port wr_sel_o  output  CH  one-hot target select, valid with wr_en_o.
REQ-011 The block SHALL have port wr_addr_o  output  AW  word address, valid with wr_en_o.
REQ-012 The block SHALL have port wr_data_o  output  XLEN  write word, little-endian byte lanes.
REQ-013 The block SHALL have port wr_byte_en_o  output  XLEN/8  lane enables, valid with wr_en_o.
REQ-014 The block SHALL have port cpu_rst_n_o  output  1  CPU reset, active low; low while not in RUN.
REQ-015 The block SHALL have port busy_o  output  1  high in LOAD.
REQ-016 The block SHALL have port err_o  output  1  sticky protocol error.
REQ-017 The block SHALL have port csum_o  output  8  modulo-256 sum of accepted data bytes.

Function
REQ-018 The block SHALL implement states IDLE, LOAD and RUN; commands are decoded only on byte_rdy_i=1 with dc_i=0.
REQ-019 Command 0x00 HALT SHALL flush, then go to IDLE.
REQ-020 Command 0x01 RUN SHALL flush, then go to RUN; cpu_rst_n_o SHALL rise on the cycle after the flush write, or the cycle after the command if there is nothing to flush.
REQ-021 Command 0x10 SHALL clear err_o and csum_o, with no state change.
REQ-022 Command 0x2k with k<CH SHALL flush, then enter LOAD with target k, word address 0 and lane 0; cpu_rst_n_o=0; legal from any state.
REQ-023 Command 0x2k with k>=CH, or any other undefined command, SHALL set err_o with no state, address or target change.
REQ-024 A data byte in LOAD SHALL be stored in the current lane; the lane index increments; csum_o += byte, mod 256.
REQ-025 When the byte completing lane XLEN/8-1 is accepted, the block SHALL write the full word: wr_en_o=1 on the next cycle, byte_en all ones, the current address; then the address increments and the lane index returns to 0.
REQ-026 The address SHALL wrap from DEPTH-1 to 0 silently.
REQ-027 Flush: if lane>0, the block SHALL issue one write with byte_en covering only the received lanes, unreceived lanes' data 0, then increment the address and reset the lane; if lane=0, no write.
REQ-028 A data byte received in IDLE or RUN SHALL be ignored, set err_o, and leave csum_o unchanged.
REQ-029 All outputs SHALL be registered; wr_en_o high for exactly 1 cycle per write; wr_sel_o, wr_addr_o, wr_data_o and wr_byte_en_o SHALL be 0 when wr_en_o=0.
REQ-030 The block SHALL accept byte_rdy_i on every consecutive cycle with no byte lost; sustained throughput is 1 word per XLEN/8 cycles.

Reset
REQ-031 While rst_n_i=0: state IDLE, lane 0, address 0, target 0; all outputs 0, including cpu_rst_n_o=0.
REQ-032 Reset asserted mid-word SHALL discard the partial word and generate no write; after release, the block SHALL wait for a command.

Verification (XLEN=32, DEPTH=2048, CH=2)
REQ-033 0x20 then data 11 22 33 44 -> one write: sel=01, addr=0, data=0x44332211, be=F; busy_o=1; cpu_rst_n_o=0; csum_o=0xAA.
REQ-034 0x21, data 01..06, then 0x01 -> write addr0 0x04030201 be=F sel=10; flush write addr1 0x00000605 be=3; cpu_rst_n_o=1 on the cycle after the flush; busy_o=0.
REQ-035 0x20 then 8200 data bytes, one per cycle -> writes exactly 4 cycles apart; the 2049th write is at addr 0; err_o=0.
REQ-036 Reset, then data byte 0x55 -> err_o=1, no write; then 0x25 -> no change, err_o stays 1; then 0x10 -> err_o=0, csum_o=0.
REQ-037 0x20, data AA BB, then assert rst_n_i mid-cycle -> outputs 0 immediately, no write; after release, 0x20 and 4 bytes -> write at addr 0.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: byte-stream loader; dc_i/byte_rdy_i/byte_data_i in, registered word writes (wr_*_o), cpu_rst_n_o, busy_o, err_o, csum_o out
module mem_loader #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2048,
  parameter int CH    = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int NB   = XLEN / 8,
  localparam int LW   = $clog2(NB)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            dc_i,
  input  logic            byte_rdy_i,
  input  logic [7:0]      byte_data_i,
  output logic            wr_en_o,
  output logic [CH-1:0]   wr_sel_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [NB-1:0]   wr_byte_en_o,
  output logic            cpu_rst_n_o,
  output logic            busy_o,
  output logic            err_o,
  output logic [7:0]      csum_o
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] tgt_q, tgt_d;
  logic [AW-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [XLEN-1:0] buf_q, buf_d, wdata_q, wdata_d, word, fdata;
  logic [NB-1:0] be_q, be_d, fbe;
  logic [CH-1:0] sel_q, sel_d;
  logic wr_en_q, wr_en_d, cpu_q, cpu_d, busy_q, busy_d, err_q, err_d, flush, is_ld;
  logic [7:0] csum_q, csum_d;
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    addr_d = addr_q;
    lane_d = lane_q;
    buf_d = buf_q;
    err_d = err_q;
    csum_d = csum_q;
    wr_en_d = 1'b0;
    sel_d = '0;
    waddr_d = '0;
    wdata_d = '0;
    be_d = '0;
    flush = 1'b0;
    word = buf_q;
    fbe = '0;
    fdata = '0;
    for (int i = 0; i < NB; i++) begin
      if (LW'(i) == lane_q) word[8*i +: 8] = byte_data_i;
      fbe[i] = LW'(i) < lane_q;
      fdata[8*i +: 8] = fbe[i] ? buf_q[8*i +: 8] : 8'h00;
    end
    is_ld = byte_data_i[7:4] == 4'h2 && {1'b0, byte_data_i[3:0]} < 5'(CH);
    if (byte_rdy_i && dc_i) begin
      if (state_q == LOAD) begin
        csum_d = csum_q + byte_data_i;
        buf_d = word;
        lane_d = lane_q + LW'(1);
        if (lane_q == LW'(NB - 1)) begin
          wr_en_d = 1'b1;
          sel_d = CH'(1) << tgt_q;
          waddr_d = addr_q;
          wdata_d = word;
          be_d = '1;
          addr_d = addr_q + AW'(1);
          lane_d = '0;
        end
      end else err_d = 1'b1;
    end else if (byte_rdy_i) begin
      flush = (byte_data_i == 8'h00 || byte_data_i == 8'h01 || is_ld) && lane_q != '0;
      if (flush) begin
        wr_en_d = 1'b1;
        sel_d = CH'(1) << tgt_q;
        waddr_d = addr_q;
        wdata_d = fdata;
        be_d = fbe;
        addr_d = addr_q + AW'(1);
        lane_d = '0;
      end
      if (byte_data_i == 8'h00) state_d = IDLE;
      else if (byte_data_i == 8'h01) state_d = RUN;
      else if (byte_data_i == 8'h10) begin
        err_d = 1'b0;
        csum_d = '0;
      end else if (is_ld) begin
        state_d = LOAD;
        tgt_d = byte_data_i[3:0];
        addr_d = '0;
        lane_d = '0;
      end else err_d = 1'b1;
    end
    // a flushing RUN command holds the CPU in reset one extra cycle so the write lands first
    cpu_d = state_d == RUN && !flush;
    busy_d = state_d == LOAD;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      tgt_q <= '0;
      addr_q <= '0;
      lane_q <= '0;
      buf_q <= '0;
      wr_en_q <= 1'b0;
      sel_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      cpu_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      csum_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      addr_q <= addr_d;
      lane_q <= lane_d;
      buf_q <= buf_d;
      wr_en_q <= wr_en_d;
      sel_q <= sel_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      cpu_q <= cpu_d;
      busy_q <= busy_d;
      err_q <= err_d;
      csum_q <= csum_d;
    end
  end
  assign wr_en_o = wr_en_q;
  assign wr_sel_o = sel_q;
  assign wr_addr_o = waddr_q;
  assign wr_data_o = wdata_q;
  assign wr_byte_en_o = be_q;
  assign cpu_rst_n_o = cpu_q;
  assign busy_o = busy_q;
  assign err_o = err_q;
  assign csum_o = csum_q;
endmodule
